// File: rtl/div_bcd_formatter.sv
// Sequential binary-to-BCD formatter for the divider's quotient/remainder pair.
// Both operands run double dabble in lockstep, one bit per cycle, then hold until consumed.
module div_bcd_formatter #(
  parameter int unsigned W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  quotient,
  input  logic [W-1:0]  remainder,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [11:0]   q_bcd,
  output logic [11:0]   r_bcd
);

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StDone
  } state_e;

  localparam logic [W-1:0] LastCnt = W'(W - 1);
  localparam logic [W-1:0] CntOne  = W'(1);

  state_e        state_q, state_d;
  logic [W-1:0]  q_sh_q, q_sh_d;
  logic [W-1:0]  r_sh_q, r_sh_d;
  logic [11:0]   q_scr_q, q_scr_d;
  logic [11:0]   r_scr_q, r_scr_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [11:0]   q_bcd_q, q_bcd_d;
  logic [11:0]   r_bcd_q, r_bcd_d;

  logic [12+W-1:0] q_step;
  logic [12+W-1:0] r_step;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift {bcd, bin} left.
  function automatic logic [12+W-1:0] dd_step(input logic [11:0] bcd, input logic [W-1:0] bin);
    logic [11:0] adj;
    logic [3:0]  nib;
    adj = '0;
    for (int i = 0; i < 3; i++) begin
      nib = bcd[4*i +: 4];
      adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    return {adj, bin} << 1;
  endfunction

  always_comb begin
    state_d = state_q;
    q_sh_d  = q_sh_q;
    r_sh_d  = r_sh_q;
    q_scr_d = q_scr_q;
    r_scr_d = r_scr_q;
    cnt_d   = cnt_q;
    q_bcd_d = q_bcd_q;
    r_bcd_d = r_bcd_q;
    q_step  = dd_step(q_scr_q, q_sh_q);
    r_step  = dd_step(r_scr_q, r_sh_q);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          q_sh_d  = quotient;
          r_sh_d  = remainder;
          q_scr_d = '0;
          r_scr_d = '0;
          cnt_d   = '0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        q_scr_d = q_step[12+W-1:W];
        q_sh_d  = q_step[W-1:0];
        r_scr_d = r_step[12+W-1:W];
        r_sh_d  = r_step[W-1:0];
        cnt_d   = cnt_q + CntOne;
        if (cnt_q == LastCnt) begin
          q_bcd_d = q_step[12+W-1:W];
          r_bcd_d = r_step[12+W-1:W];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_sh_q  <= '0;
      r_sh_q  <= '0;
      q_scr_q <= '0;
      r_scr_q <= '0;
      cnt_q   <= '0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
    end else begin
      state_q <= state_d;
      q_sh_q  <= q_sh_d;
      r_sh_q  <= r_sh_d;
      q_scr_q <= q_scr_d;
      r_scr_q <= r_scr_d;
      cnt_q   <= cnt_d;
      q_bcd_q <= q_bcd_d;
      r_bcd_q <= r_bcd_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign q_bcd     = q_bcd_q;
  assign r_bcd     = r_bcd_q;

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Self-checking bench for div_bcd_formatter: decimal reference model compared every cycle,
// plus directed transactions with hand-computed BCD results and latency.
module tb_div_bcd_formatter;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient = '0;
  logic [W-1:0] remainder = '0;
  logic         in_ready;
  logic         out_valid;
  logic [11:0]  q_bcd;
  logic [11:0]  r_bcd;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  div_bcd_formatter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view (accept, W cycles of work, hold until consumed).
  logic       m_busy = 1'b0;
  logic       m_valid = 1'b0;
  int         m_left = 0;
  logic [11:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  int         cyc = 0;
  int         acc_cyc[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_q     <= '0;
      m_r     <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_q     <= p_q;
          m_r     <= p_r;
        end
      end else if (m_valid) begin
        if (out_ready) m_valid <= 1'b0;
      end else if (in_valid) begin
        p_q    <= to_bcd(int'(quotient));
        p_r    <= to_bcd(int'(remainder));
        m_left <= W;
        m_busy <= 1'b1;
        acc_cyc.push_back(cyc + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, ~m_busy & ~m_valid});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("q_bcd", {20'd0, q_bcd}, {20'd0, m_q});
      chk("r_bcd", {20'd0, r_bcd}, {20'd0, m_r});
      if (out_valid) begin
        for (int i = 0; i < 3; i++) begin
          chk("q_digit_le9", {31'd0, q_bcd[4*i +: 4] <= 4'd9}, 32'd1);
          chk("r_digit_le9", {31'd0, r_bcd[4*i +: 4] <= 4'd9}, 32'd1);
        end
      end
    end
  end

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_timeout"}, {31'd0, out_valid}, 32'd1);
  endtask

  // Accept one pair, measure edges to out_valid, check literal result, then consume it.
  task automatic run_txn(input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic [11:0] eq, input logic [11:0] er, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid  = 1'b1;
    quotient  = q;
    remainder = r;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    quotient  = W'($urandom);
    remainder = W'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, W);
    chk({tag, "_q"}, {20'd0, q_bcd}, {20'd0, eq});
    chk({tag, "_r"}, {20'd0, r_bcd}, {20'd0, er});
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [11:0] save_q, save_r;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {20'd0, q_bcd}, 32'd0);
    chk("rst_r", {20'd0, r_bcd}, 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    run_txn(8'd28, 8'd4, 12'h028, 12'h004, "t200_7");
    run_txn(8'd255, 8'd0, 12'h255, 12'h000, "tmax");
    run_txn(8'd0, 8'd99, 12'h000, 12'h099, "tzero");

    // Backpressure with new operands offered throughout.
    @(negedge clk);
    in_valid = 1'b1; quotient = 8'd123; remainder = 8'd45;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("bp");
    save_q = q_bcd;
    save_r = r_bcd;
    chk("bp_q", {20'd0, q_bcd}, 32'h123);
    chk("bp_r", {20'd0, r_bcd}, 32'h045);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      quotient  = W'($urandom);
      remainder = W'($urandom);
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_q", {20'd0, q_bcd}, {20'd0, save_q});
      chk("bp_hold_r", {20'd0, r_bcd}, {20'd0, save_r});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_kept_q", {20'd0, q_bcd}, 32'h123);
    chk("bp_idle", {31'd0, in_ready}, 32'd1);

    // Back-to-back with both handshakes tied high.
    acc_cyc.delete();
    out_ready = 1'b1; in_valid = 1'b1; quotient = 8'd33; remainder = 8'd1;
    begin
      int n;
      n = 0;
      while (acc_cyc.size() < 1 && n < 50) begin @(negedge clk); n++; end
      quotient = 8'd9; remainder = 8'd9;
      wait_valid("b2b1");
      chk("b2b1_q", {20'd0, q_bcd}, 32'h033);
      chk("b2b1_r", {20'd0, r_bcd}, 32'h001);
      n = 0;
      while (acc_cyc.size() < 2 && n < 50) begin @(negedge clk); n++; end
      chk("b2b_accepts", acc_cyc.size(), 2);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid("b2b2");
      chk("b2b2_q", {20'd0, q_bcd}, 32'h009);
      chk("b2b2_r", {20'd0, r_bcd}, 32'h009);
      if (acc_cyc.size() >= 2) chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], W + 2);
    end
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    // Reset pulse four cycles into CONVERT.
    in_valid = 1'b1; quotient = 8'd200; remainder = 8'd150;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_q", {20'd0, q_bcd}, 32'd0);
    chk("arst_r", {20'd0, r_bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    run_txn(8'd45, 8'd6, 12'h045, 12'h006, "post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      quotient  = W'($urandom);
      remainder = W'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
